// File: rtl/datamemory_sized_if.sv
// Request/response bundle for the sized data memory: one request per cycle in, registered load result out.
interface datamemory_sized_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  en;
  logic                  rd_wr;
  logic [1:0]            tamanho;
  logic                  sinal;
  logic [ADDR_WIDTH-1:0] endereco;
  logic [31:0]           entrada;
  logic [31:0]           saida;
  logic                  valido;
  logic                  erro_alinh;
  logic                  ocupado;

  modport master (
    output en, rd_wr, tamanho, sinal, endereco, entrada,
    input  saida, valido, erro_alinh, ocupado
  );

  modport slave (
    input  en, rd_wr, tamanho, sinal, endereco, entrada,
    output saida, valido, erro_alinh, ocupado
  );
endinterface

// File: rtl/datamemory_sized.sv
// Byte/half/word data memory with clear-on-reset sequencer; loads return 1 cycle after the request.
// No backpressure: requests are dropped while ocupado is high, misaligned/illegal ones raise erro_alinh.
module datamemory_sized #(
  parameter int ADDR_WIDTH = 10,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                Clk,
  input  logic                Rst_n,
  datamemory_sized_if.slave   bus
);
  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       saida_q, saida_d;
  logic              valido_q, valido_d;
  logic              erro_q, erro_d;

  logic [31:0]       mem [DEPTH];

  logic [1:0]        off;
  logic [IDX_W-1:0]  idx;
  logic [4:0]        sh;
  logic [31:0]       mask;
  logic              aligned;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shift;
  logic [31:0]       load_val;
  logic              we;
  logic [IDX_W-1:0]  widx;
  logic [31:0]       wdata;

  assign off = bus.endereco[1:0];
  assign idx = bus.endereco[ADDR_WIDTH-1:2];

  // Lane position in bits of the addressed item within its word.
  always_comb begin
    sh      = 5'd0;
    mask    = 32'hFFFF_FFFF;
    aligned = 1'b0;
    case (bus.tamanho)
      2'b00: begin
        sh      = BIG_ENDIAN ? {~off, 3'b000} : {off, 3'b000};
        mask    = 32'h0000_00FF << sh;
        aligned = 1'b1;
      end
      2'b01: begin
        sh      = BIG_ENDIAN ? {~off[1], 1'b0, 3'b000} : {off[1], 1'b0, 3'b000};
        mask    = 32'h0000_FFFF << sh;
        aligned = ~off[0];
      end
      2'b10: aligned = (off == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign rd_word  = mem[idx];
  assign rd_shift = rd_word >> sh;

  always_comb begin
    load_val = rd_shift;
    case (bus.tamanho)
      2'b00: load_val = bus.sinal ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                  : {24'h0, rd_shift[7:0]};
      2'b01: load_val = bus.sinal ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                  : {16'h0, rd_shift[15:0]};
      default: load_val = rd_shift;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    saida_d  = saida_q;
    valido_d = 1'b0;
    erro_d   = 1'b0;
    we       = 1'b0;
    widx     = idx;
    wdata    = (rd_word & ~mask) | ((bus.entrada << sh) & mask);
    case (state_q)
      INIT: begin
        we    = 1'b1;
        widx  = cnt_q;
        wdata = 32'h0;
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        if (bus.en) begin
          if (!aligned) begin
            erro_d = 1'b1;
          end else if (bus.rd_wr) begin
            we = 1'b1;
          end else begin
            saida_d  = load_val;
            valido_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      saida_q  <= 32'h0;
      valido_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      saida_q  <= saida_d;
      valido_q <= valido_d;
      erro_q   <= erro_d;
    end
  end

  // Storage is not reset; the INIT sweep clears it after every reset.
  always_ff @(posedge Clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign bus.saida      = saida_q;
  assign bus.valido     = valido_q;
  assign bus.erro_alinh = erro_q;
  assign bus.ocupado    = (state_q == INIT);
endmodule

// File: tb/tb_datamemory_sized.sv
// Randomized bench for datamemory_sized against a byte-array reference model.
module tb_datamemory_sized;
  localparam int AW = 10;
  localparam bit BE = 1'b1;

  logic Clk;
  logic Rst_n;
  int   n_err;
  int   n_chk;

  logic [7:0]  mbytes [1024];
  logic [31:0] exp_saida;

  datamemory_sized_if #(.ADDR_WIDTH(AW)) bus ();

  datamemory_sized #(.ADDR_WIDTH(AW), .BIG_ENDIAN(BE)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int sz(input logic [1:0] tam);
    return (tam == 2'b00) ? 1 : (tam == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] mload(input logic [1:0] tam, input bit sg, input logic [9:0] a);
    logic [31:0] v;
    int n;
    n = sz(tam);
    v = 32'h0;
    for (int k = 0; k < n; k++) begin
      if (BE) v = (v << 8) | 32'(mbytes[int'(a) + k]);
      else    v = v | (32'(mbytes[int'(a) + k]) << (8 * k));
    end
    if (sg && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (sg && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic mstore(input logic [1:0] tam, input logic [9:0] a, input logic [31:0] d);
    int n;
    n = sz(tam);
    for (int k = 0; k < n; k++) begin
      if (BE) mbytes[int'(a) + k] = 8'(d >> (8 * (n - 1 - k)));
      else    mbytes[int'(a) + k] = 8'(d >> (8 * k));
    end
  endtask

  task automatic mclear();
    for (int i = 0; i < 1024; i++) mbytes[i] = 8'h00;
    exp_saida = 32'h0;
  endtask

  // One request per call: drive at negedge, compare registered outputs just after the edge.
  task automatic req(input string tag, input bit e, input bit rw, input logic [1:0] tam,
                     input bit sg, input logic [9:0] a, input logic [31:0] d);
    bit ok;
    bit exp_v;
    bit exp_e;
    @(negedge Clk);
    bus.en = e; bus.rd_wr = rw; bus.tamanho = tam; bus.sinal = sg;
    bus.endereco = a; bus.entrada = d;
    ok = (tam == 2'b00) || (tam == 2'b01 && !a[0]) || (tam == 2'b10 && a[1:0] == 2'b00);
    exp_v = 1'b0;
    exp_e = 1'b0;
    if (e && !ok) exp_e = 1'b1;
    else if (e && rw) mstore(tam, a, d);
    else if (e) begin
      exp_saida = mload(tam, sg, a);
      exp_v = 1'b1;
    end
    @(posedge Clk);
    #1;
    chk({tag, ".valido"}, 32'(bus.valido), 32'(exp_v));
    chk({tag, ".erro"}, 32'(bus.erro_alinh), 32'(exp_e));
    chk({tag, ".saida"}, bus.saida, exp_saida);
  endtask

  task automatic wait_init(input string tag);
    int n;
    int noisy;
    n = 0;
    noisy = 0;
    while (n < 400) begin
      @(posedge Clk);
      #1;
      n++;
      if (bus.valido || bus.erro_alinh) noisy++;
      if (!bus.ocupado) break;
    end
    chk({tag, ".init_cycles"}, 32'(n), 32'd256);
    chk({tag, ".init_quiet"}, 32'(noisy), 32'd0);
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    mclear();
    Rst_n = 1'b0;
    bus.en = 1'b0; bus.rd_wr = 1'b0; bus.tamanho = 2'b00; bus.sinal = 1'b0;
    bus.endereco = '0; bus.entrada = 32'h0;
    #23;
    chk("rst.saida", bus.saida, 32'h0);
    chk("rst.valido", 32'(bus.valido), 32'h0);
    chk("rst.erro", 32'(bus.erro_alinh), 32'h0);
    chk("rst.ocupado", 32'(bus.ocupado), 32'h1);

    // A store held on the bus for the whole clear sweep must be ignored.
    @(negedge Clk);
    Rst_n = 1'b1;
    bus.en = 1'b1; bus.rd_wr = 1'b1; bus.tamanho = 2'b10;
    bus.endereco = 10'h0AC; bus.entrada = 32'h1234_5678;
    wait_init("init1");
    @(negedge Clk);
    bus.en = 1'b0;

    req("lw3fc", 1, 0, 2'b10, 0, 10'h3FC, 32'h0);
    req("lw0ac", 1, 0, 2'b10, 0, 10'h0AC, 32'h0);

    req("sw010", 1, 1, 2'b10, 0, 10'h010, 32'h8000_00F0);
    req("lb010", 1, 0, 2'b00, 1, 10'h010, 32'h0);
    chk("lb010.value", bus.saida, 32'hFFFF_FF80);
    req("lbu013", 1, 0, 2'b00, 0, 10'h013, 32'h0);
    chk("lbu013.value", bus.saida, 32'h0000_00F0);
    req("lhu010", 1, 0, 2'b01, 0, 10'h010, 32'h0);
    chk("lhu010.value", bus.saida, 32'h0000_8000);
    req("lh012", 1, 0, 2'b01, 1, 10'h012, 32'h0);
    chk("lh012.value", bus.saida, 32'h0000_00F0);

    req("sw020", 1, 1, 2'b10, 0, 10'h020, 32'h1122_3344);
    req("sb021", 1, 1, 2'b00, 0, 10'h021, 32'h0000_00AB);
    req("lw020", 1, 0, 2'b10, 0, 10'h020, 32'h0);
    chk("lw020.value", bus.saida, 32'h11AB_3344);

    req("lw006", 1, 0, 2'b10, 0, 10'h006, 32'h0);
    req("sh003", 1, 1, 2'b01, 0, 10'h003, 32'h0000_BEEF);
    req("tam11", 1, 0, 2'b11, 0, 10'h000, 32'h0);
    req("idle", 0, 0, 2'b00, 0, 10'h000, 32'h0);
    req("lw000", 1, 0, 2'b10, 0, 10'h000, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic [9:0] a;
      a = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 63));
      req("rand", ($urandom_range(0, 7) != 0), 1'($urandom), 2'($urandom),
          1'($urandom), a, $urandom);
    end

    req("sw040", 1, 1, 2'b10, 0, 10'h040, 32'hCAFE_BABE);
    req("lw040", 1, 0, 2'b10, 0, 10'h040, 32'h0);
    chk("lw040.value", bus.saida, 32'hCAFE_BABE);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("midrst.saida", bus.saida, 32'h0);
    chk("midrst.valido", 32'(bus.valido), 32'h0);
    chk("midrst.ocupado", 32'(bus.ocupado), 32'h1);
    bus.en = 1'b0;
    mclear();
    @(negedge Clk);
    Rst_n = 1'b1;
    wait_init("init2");
    req("lw040b", 1, 0, 2'b10, 0, 10'h040, 32'h0);
    req("lw020b", 1, 0, 2'b10, 0, 10'h020, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
